// File: rtl/axi_rx_frame_validator_pkg.sv
`default_nettype none
// ============================================================================
// rx_frame_pkg : shared state encoding and default sizes for the RX validator
// Revision 1.0
// ============================================================================
package rx_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int c_def_min_frame_bytes = 64;
    localparam int c_def_max_frame_bytes = 1518;
    localparam int c_def_cnt_width       = 16;

endpackage
`default_nettype wire

// File: rtl/axi_rx_frame_validator_skid_buffer.sv
`default_nettype none
// ============================================================================
// axis_skid_buffer : 2-entry AXI-Stream skid buffer (data+last+user),
//                    registered upstream ready. Revision 1.0
// ============================================================================
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_user,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_user,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int c_w = DATA_WIDTH + 2;

    logic [c_w-1:0] w_in;
    logic [c_w-1:0] out_q, out_d;
    logic [c_w-1:0] skid_q, skid_d;
    logic           out_vld_q, out_vld_d;
    logic           skid_vld_q, skid_vld_d;
    logic           rdy_q, rdy_d;
    logic           w_push;

    assign w_in   = {s_user, s_last, s_data};
    assign w_push = s_valid & rdy_q;

    // The skid entry only fills while the output register is stalled, so
    // a full skid always implies a full output register.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (m_ready || !out_vld_q) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = w_push;
                if (w_push) begin
                    out_d = w_in;
                end
            end
        end else if (w_push) begin
            skid_d     = w_in;
            skid_vld_d = 1'b1;
        end
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign s_ready = rdy_q;
    assign m_valid = out_vld_q;
    assign m_data  = out_q[DATA_WIDTH-1:0];
    assign m_last  = out_q[DATA_WIDTH];
    assign m_user  = out_q[DATA_WIDTH+1];

endmodule
`default_nettype wire

// File: rtl/axi_rx_frame_validator.sv
`default_nettype none
// ============================================================================
// axi_rx_frame_validator : flags runt/oversize/errored frames via tuser on
// tlast ahead of a packet FIFO. Optional counters: RX_FRAME_STATS_EN.
// Revision 1.0
// ============================================================================
module axi_rx_frame_validator
    import rx_frame_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 8,
    parameter int MIN_FRAME_BYTES = c_def_min_frame_bytes,
    parameter int MAX_FRAME_BYTES = c_def_max_frame_bytes,
    parameter int CNT_WIDTH       = c_def_cnt_width
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic                      s_axis_trdy,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    input  logic                      m_axis_trdy,
    output logic                      o_frame_good,
    output logic                      o_frame_bad,
    output logic [CNT_WIDTH-1:0]      o_frame_len,
    output logic [31:0]               o_good_cnt,
    output logic [31:0]               o_bad_cnt,
    output logic [31:0]               o_trunc_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_max_plus1 = CNT_WIDTH'(MAX_FRAME_BYTES + 1);
    localparam logic [CNT_WIDTH-1:0] c_min       = CNT_WIDTH'(MIN_FRAME_BYTES);
    localparam int                   c_side_w    = AXI_DATA_WIDTH + CNT_WIDTH;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                 err_sticky_q, err_sticky_d;
    logic                 frame_good_q, frame_good_d;
    logic                 frame_bad_q, frame_bad_d;
    logic [CNT_WIDTH-1:0] frame_len_q, frame_len_d;

    logic [CNT_WIDTH-1:0] w_cnt_now;
    logic                 w_skid_ready;
    logic                 w_accept;
    logic                 w_emit;
    logic                 w_emit_last;
    logic                 w_emit_user;
    logic [c_side_w-1:0]  w_skid_out;
    logic [CNT_WIDTH-1:0] w_out_len;
    logic                 w_dn_last_hs;

    assign s_axis_trdy = (state_q == DROP) | w_skid_ready;
    assign w_accept    = s_axis_tvalid & s_axis_trdy;
    assign w_cnt_now   = beat_cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        err_sticky_d = err_sticky_q;
        w_emit       = 1'b0;
        w_emit_last  = 1'b0;
        w_emit_user  = 1'b0;
        if (w_accept) begin
            case (state_q)
                IDLE, PASS: begin
                    w_emit = 1'b1;
                    if (w_cnt_now == c_max_plus1) begin
                        // Oversize: cut the frame here and swallow the remainder.
                        w_emit_last  = 1'b1;
                        w_emit_user  = 1'b1;
                        beat_cnt_d   = '0;
                        err_sticky_d = 1'b0;
                        state_d      = s_axis_tlast ? IDLE : DROP;
                    end else if (s_axis_tlast) begin
                        w_emit_last  = 1'b1;
                        w_emit_user  = err_sticky_q | s_axis_tuser | (w_cnt_now < c_min);
                        beat_cnt_d   = '0;
                        err_sticky_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        beat_cnt_d   = w_cnt_now;
                        err_sticky_d = err_sticky_q | s_axis_tuser;
                        state_d      = PASS;
                    end
                end
                DROP: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Frame length rides alongside the data so stats line up with the
    // downstream handshake rather than input acceptance.
    axis_skid_buffer #(
        .DATA_WIDTH (c_side_w)
    ) u_skid (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_data  ({w_cnt_now, s_axis_tdata}),
        .s_last  (w_emit_last),
        .s_user  (w_emit_user),
        .s_valid (w_emit),
        .s_ready (w_skid_ready),
        .m_data  (w_skid_out),
        .m_last  (m_axis_tlast),
        .m_user  (m_axis_tuser),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_trdy)
    );

    assign m_axis_tdata = w_skid_out[AXI_DATA_WIDTH-1:0];
    assign w_out_len    = w_skid_out[c_side_w-1:AXI_DATA_WIDTH];
    assign w_dn_last_hs = m_axis_tvalid & m_axis_trdy & m_axis_tlast;

    always_comb begin
        frame_good_d = w_dn_last_hs & ~m_axis_tuser;
        frame_bad_d  = w_dn_last_hs & m_axis_tuser;
        frame_len_d  = w_dn_last_hs ? w_out_len : frame_len_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            err_sticky_q <= 1'b0;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            err_sticky_q <= err_sticky_d;
            frame_good_q <= frame_good_d;
            frame_bad_q  <= frame_bad_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign o_frame_good = frame_good_q;
    assign o_frame_bad  = frame_bad_q;
    assign o_frame_len  = frame_len_q;

`ifdef RX_FRAME_STATS_EN
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] bad_cnt_q, bad_cnt_d;
    logic [31:0] trunc_cnt_q, trunc_cnt_d;

    // Only truncated frames ever carry a length of MAX+1.
    always_comb begin
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        trunc_cnt_d = trunc_cnt_q;
        if (w_dn_last_hs) begin
            if (m_axis_tuser) begin
                bad_cnt_d = bad_cnt_q + 32'd1;
            end else begin
                good_cnt_d = good_cnt_q + 32'd1;
            end
            if (w_out_len == c_max_plus1) begin
                trunc_cnt_d = trunc_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            trunc_cnt_q <= '0;
        end else begin
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign o_good_cnt  = good_cnt_q;
    assign o_bad_cnt   = bad_cnt_q;
    assign o_trunc_cnt = trunc_cnt_q;
`else
    assign o_good_cnt  = '0;
    assign o_bad_cnt   = '0;
    assign o_trunc_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_rx_frame_validator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_axi_rx_frame_validator : directed + randomized frames against a
// frame-level reference model. Revision 1.0
// ============================================================================
module tb_axi_rx_frame_validator;

    localparam int c_min = 64;
    localparam int c_max = 1518;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_trdy;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_trdy = 1'b1;
    logic        o_frame_good;
    logic        o_frame_bad;
    logic [15:0] o_frame_len;
    logic [31:0] o_good_cnt;
    logic [31:0] o_bad_cnt;
    logic [31:0] o_trunc_cnt;

    axi_rx_frame_validator dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_trdy   (s_axis_trdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_trdy   (m_axis_trdy),
        .o_frame_good  (o_frame_good),
        .o_frame_bad   (o_frame_bad),
        .o_frame_len   (o_frame_len),
        .o_good_cnt    (o_good_cnt),
        .o_bad_cnt     (o_bad_cnt),
        .o_trunc_cnt   (o_trunc_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [15:0] len;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  data_arr [0:1600];
    bit          err_map [0:1600];
    int          occ = 0;
    bit          in_drop = 1'b0;
    bit          drv_emit = 1'b0;
    int          rel_cyc = 0;
    int          cyc = 0;
    bit          pend_good = 1'b0;
    bit          pend_bad = 1'b0;
    logic [15:0] pend_len = '0;
    int          n_good_pulse = 0;
    int          n_bad_pulse = 0;
    logic [31:0] exp_good_cnt = '0;
    logic [31:0] exp_bad_cnt = '0;
    logic [31:0] exp_trunc_cnt = '0;
    int          out_first_cyc = 0;
    int          out_last_cyc = 0;
    bit          out_in_frame = 1'b0;
    bit          stall_en = 1'b0;
    int          up_gap_pct = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge aclk) begin
        #1;
        m_axis_trdy = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    always @(posedge aclk) begin
        cyc++;
        if (!aresetn) rel_cyc = 0;
        else          rel_cyc++;
    end

    // Downstream monitor / scoreboard
    always @(negedge aclk) begin
        beat_t e;
        int    push;
        int    pop;
        if (aresetn) begin
            check("frame_good_pulse", o_frame_good, pend_good);
            check("frame_bad_pulse", o_frame_bad, pend_bad);
            if (pend_good || pend_bad) check("frame_len", o_frame_len, pend_len);
            if (o_frame_good) n_good_pulse++;
            if (o_frame_bad)  n_bad_pulse++;
            if (rel_cyc >= 1) check("s_axis_trdy", s_axis_trdy, (occ < 2) || in_drop);
            pend_good = 1'b0;
            pend_bad  = 1'b0;
            if (m_axis_tvalid && m_axis_tuser) check("tuser_needs_tlast", m_axis_tlast, 1);
            push = (s_axis_tvalid && s_axis_trdy && drv_emit) ? 1 : 0;
            pop  = (m_axis_tvalid && m_axis_trdy) ? 1 : 0;
            if (pop == 1) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_tdata", m_axis_tdata, e.data);
                    check("out_tlast", m_axis_tlast, e.last);
                    check("out_tuser", m_axis_tuser, e.user);
                    if (!out_in_frame) begin
                        out_first_cyc = cyc;
                        out_in_frame  = 1'b1;
                    end
                    if (e.last) begin
                        out_last_cyc = cyc;
                        out_in_frame = 1'b0;
                        pend_good    = ~e.user;
                        pend_bad     = e.user;
                        pend_len     = e.len;
                        if (e.user) exp_bad_cnt++;
                        else        exp_good_cnt++;
                        if (e.len == 16'(c_max + 1)) exp_trunc_cnt++;
                    end
                end
            end
            occ = occ + push - pop;
        end
    end

    task automatic wait_accept();
        bit acc;
        int t;
        t = 0;
        do begin
            @(negedge aclk);
            acc = s_axis_tvalid && s_axis_trdy;
            @(posedge aclk);
            #1;
            t++;
            if (!acc && t > 3000) begin
                $display("FAIL accept_timeout: observed no handshake after %0d cycles, required one", t);
                $fatal(1);
            end
        end while (!acc);
    endtask

    task automatic clear_err();
        for (int i = 0; i <= 1600; i++) err_map[i] = 1'b0;
    endtask

    // Model: the first min(len, MAX+1) bytes pass; the last of them carries
    // tlast, and tuser = oversize | runt | any error among those bytes.
    task automatic send_frame(input int len, input int abort_at);
        beat_t e;
        int    nout;
        bit    anyerr;
        nout   = (len > c_max) ? c_max + 1 : len;
        anyerr = 1'b0;
        for (int i = 1; i <= len; i++) data_arr[i] = 8'($urandom);
        for (int i = 1; i <= nout; i++) anyerr |= err_map[i];
        for (int i = 1; i <= nout; i++) begin
            e.data = data_arr[i];
            e.last = (i == nout);
            e.user = (i == nout) && (anyerr || len > c_max || len < c_min);
            e.len  = 16'(nout);
            exp_q.push_back(e);
        end
        for (int i = 1; i <= len; i++) begin
            if (i == abort_at) return;
            while (up_gap_pct > 0 && $urandom_range(0, 99) < up_gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = data_arr[i];
            s_axis_tlast  = (i == len);
            s_axis_tuser  = err_map[i];
            drv_emit      = (i <= c_max + 1);
            wait_accept();
            if (i == c_max + 1 && i != len) in_drop = 1'b1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        drv_emit      = 1'b0;
        in_drop       = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 8000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_s_trdy"}, s_axis_trdy, 0);
        check({tag, "_m_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_m_tlast"}, m_axis_tlast, 0);
        check({tag, "_m_tuser"}, m_axis_tuser, 0);
        check({tag, "_m_tdata"}, m_axis_tdata, 0);
        check({tag, "_good"}, o_frame_good, 0);
        check({tag, "_bad"}, o_frame_bad, 0);
        check({tag, "_len"}, o_frame_len, 0);
        check({tag, "_good_cnt"}, o_good_cnt, 0);
        check({tag, "_bad_cnt"}, o_bad_cnt, 0);
        check({tag, "_trunc_cnt"}, o_trunc_cnt, 0);
    endtask

    task automatic frame_step(input string tag, input int len, input int exp_good, input int exp_len);
        int g0;
        int b0;
        g0 = n_good_pulse;
        b0 = n_bad_pulse;
        send_frame(len, 0);
        drain();
        check({tag, "_good_pulses"}, n_good_pulse - g0, exp_good);
        check({tag, "_bad_pulses"}, n_bad_pulse - b0, 1 - exp_good);
        check({tag, "_frame_len"}, o_frame_len, exp_len);
    endtask

    initial begin
        int len;
        clear_err();
        repeat (2) @(posedge aclk);
        #1;
        check_outputs_zero("reset");
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("trdy_after_reset", s_axis_trdy, 1);

        frame_step("f64", 64, 1, 64);
        check("f64_back_to_back", out_last_cyc - out_first_cyc, 63);

        frame_step("f63_runt", 63, 0, 63);

        clear_err();
        err_map[10] = 1'b1;
        frame_step("f100_err10", 100, 0, 100);
        clear_err();

        frame_step("f1600_trunc", 1600, 0, c_max + 1);
        frame_step("f70_after_trunc", 70, 1, 70);

        stall_en   = 1'b1;
        up_gap_pct = 20;
        frame_step("f1518_stall", 1518, 1, 1518);
        stall_en   = 1'b0;
        up_gap_pct = 0;

        err_map[80] = 1'b1;
        frame_step("f80_err_last", 80, 0, 80);
        clear_err();

        frame_step("f1_runt", 1, 0, 1);
        frame_step("f1519_exact", c_max + 1, 0, c_max + 1);

`ifdef RX_FRAME_STATS_EN
        check("cnt_good_mid", o_good_cnt, exp_good_cnt);
        check("cnt_bad_mid", o_bad_cnt, exp_bad_cnt);
        check("cnt_trunc_mid", o_trunc_cnt, exp_trunc_cnt);
`endif

        // Asynchronous reset in the middle of a frame
        send_frame(64, 30);
        #2;
        aresetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        drv_emit      = 1'b0;
        in_drop       = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        exp_q.delete();
        occ           = 0;
        pend_good     = 1'b0;
        pend_bad      = 1'b0;
        out_in_frame  = 1'b0;
        exp_good_cnt  = '0;
        exp_bad_cnt   = '0;
        exp_trunc_cnt = '0;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        frame_step("f64_after_reset", 64, 1, 64);

        for (int k = 0; k < 8; k++) begin
            clear_err();
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1400, 1600) : $urandom_range(1, 200);
            if ($urandom_range(0, 2) == 0) err_map[$urandom_range(1, len)] = 1'b1;
            stall_en   = ($urandom_range(0, 1) == 1);
            up_gap_pct = $urandom_range(0, 1) * 30;
            send_frame(len, 0);
        end
        stall_en   = 1'b0;
        up_gap_pct = 0;
        drain();
        clear_err();

`ifdef RX_FRAME_STATS_EN
        check("cnt_good_end", o_good_cnt, exp_good_cnt);
        check("cnt_bad_end", o_bad_cnt, exp_bad_cnt);
        check("cnt_trunc_end", o_trunc_cnt, exp_trunc_cnt);
`else
        check("cnt_good_tied", o_good_cnt, 0);
        check("cnt_bad_tied", o_bad_cnt, 0);
        check("cnt_trunc_tied", o_trunc_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rx_frame_validator.md
Name: axi_rx_frame_validator

Overview:
- Single-clock AXI-Stream frame checker placed directly upstream of the packet-committing async FIFO's write (slave) port.
- Generates the per-frame bad-frame flag (tuser on tlast) that the FIFO uses to drop frames:
  - upstream PHY/MAC error
  - runt frames
  - oversized frames, which are truncated
- Passes good frames through unchanged with full throughput.

Parameters:
- AXI_DATA_WIDTH, 8, stream data width (one beat = one byte).
- MIN_FRAME_BYTES, 64, frames shorter than this are marked bad.
- MAX_FRAME_BYTES, 1518, longest legal frame; beyond this the frame is truncated and marked bad.
- CNT_WIDTH, 16, beat counter width; MAX_FRAME_BYTES+1 < 2**CNT_WIDTH is required.

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  AXI_DATA_WIDTH  upstream data.
- s_axis_tvalid  in  1  upstream valid.
- s_axis_tlast  in  1  upstream end of frame.
- s_axis_tuser  in  1  upstream error, valid on any beat.
- s_axis_trdy  out  1  registered ready to upstream.
- m_axis_tdata  out  AXI_DATA_WIDTH  to FIFO.
- m_axis_tvalid  out  1  to FIFO.
- m_axis_tlast  out  1  to FIFO.
- m_axis_tuser  out  1  bad-frame flag; only ever high together with tlast.
- m_axis_trdy  in  1  from FIFO.
- o_frame_good  out  1  one-cycle pulse when a good last beat is accepted downstream.
- o_frame_bad  out  1  one-cycle pulse when a bad last beat is accepted downstream.
- o_frame_len  out  CNT_WIDTH  byte length of the last completed frame; truncated frames report MAX_FRAME_BYTES+1.
- o_good_cnt  out  32  good-frame counter (optional feature).
- o_bad_cnt  out  32  bad-frame counter (optional feature).
- o_trunc_cnt  out  32  truncated-frame counter (optional feature).

Behaviour:
- Reset values: all outputs 0, including s_axis_trdy; state IDLE, counters 0, sticky error 0. s_axis_trdy rises on the first clock after aresetn deasserts.
- Output stage is a 2-entry skid buffer. s_axis_trdy is registered: high when the skid entry is empty.
- Latency: an accepted beat appears on m_axis_* on the next cycle when downstream is ready. Sustained throughput is 1 beat/cycle when m_axis_trdy stays high.
- Beat counter: counts accepted input beats in the current frame, 1-based. It is cleared on the last beat and on entering IDLE.
- err_sticky is set by s_axis_tuser on any accepted beat of a frame and cleared at end of frame.
- State machine:
  - IDLE: first accepted beat goes to PASS, or stays in IDLE if it carries tlast (1-byte frame).
  - PASS, beat with tlast and count ≤ MAX_FRAME_BYTES: emit the beat with tlast=1 and tuser = err_sticky | s_axis_tuser | (count < MIN_FRAME_BYTES). Return to IDLE.
  - PASS, beat with count == MAX_FRAME_BYTES+1: emit it with tlast=1, tuser=1 regardless of its own tlast. If its tlast=1, go to IDLE; otherwise go to DROP.
  - DROP: s_axis_trdy is forced high independent of the skid buffer. Beats are discarded and nothing is emitted. On an accepted tlast, return to IDLE.
- Non-last beats are always emitted with tuser=0, because the FIFO rewinds on tuser on any beat.
- Boundaries:
  - Frame of exactly MAX_FRAME_BYTES with tlast: good.
  - Frame of exactly MIN_FRAME_BYTES: good.
  - Error on the last beat only: bad.
  - Stats pulses are generated on the downstream handshake of the last beat, not on input acceptance.
- Reset mid-frame: the partial frame is lost with no tlast emitted. The downstream FIFO must share the reset event.

Optional Feature:
- Macro: RX_FRAME_STATS_EN.
- Defined: o_good_cnt, o_bad_cnt and o_trunc_cnt increment on the corresponding downstream last-beat handshake. They wrap at 2**32 and reset to 0.
- Not defined: these ports are tied to 0 and no counter logic is synthesized.
- o_frame_good, o_frame_bad and o_frame_len are present in both builds.

Decomposition:
- Package rx_frame_pkg:
  - state enum {IDLE, PASS, DROP}.
  - default MIN/MAX frame-size constants.
  - counter width constant.
- Natural sub-module: axis_skid_buffer (data+last+user, registered ready), reusable elsewhere.

Test Plan:
- 64-byte frame, no errors, m_axis_trdy=1: 64 beats out back-to-back; tuser=0; o_frame_good pulses once; o_frame_len=64.
- 63-byte frame: tlast on beat 63 with tuser=1; o_frame_bad pulses; o_frame_len=63.
- 100-byte frame with s_axis_tuser=1 on beat 10 only: beats 1–99 tuser=0; beat 100 tlast=1, tuser=1.
- 1600-byte frame: 1519 beats emitted, beat 1519 has tlast=1, tuser=1; beats 1520–1600 accepted and dropped; next frame passes intact.
- 1518-byte frame with random m_axis_trdy stalls (about 50%): all data in order, none lost or duplicated; tuser=0; s_axis_trdy never high while the skid entry is full.
- aresetn pulsed at beat 30 of a frame: all outputs 0 asynchronously; after release a fresh 64-byte frame validates as good.
